// File: rtl/framebuffer_scanout_if.sv
// Read-port and buffer-swap bundle between framebuffer_scanout and the
// framebuffer/renderer side.
//   draw_addr_read : {front_buf, pixel_addr} read address (scanout -> memory)
//   draw_data_out  : 1-bit pixel read data (memory -> scanout)
//   swap_req       : level request to flip the displayed buffer (renderer -> scanout)
//   swap_ack       : one-cycle pulse when the flip takes effect (scanout -> renderer)
//   front_buf      : buffer currently displayed (scanout -> renderer)
// modport master is the scanout side, modport slave the memory/renderer side.
interface framebuffer_scanout_if #(
   parameter int unsigned ADDRW = 17
) ();
   logic [ADDRW:0] draw_addr_read;
   logic           draw_data_out;
   logic           swap_req;
   logic           swap_ack;
   logic           front_buf;

   modport master (
      output draw_addr_read,
      input  draw_data_out,
      input  swap_req,
      output swap_ack,
      output front_buf
   );

   modport slave (
      input  draw_addr_read,
      output draw_data_out,
      output swap_req,
      input  swap_ack,
      input  front_buf
   );
endinterface

// File: rtl/framebuffer_scanout.sv
// Scans a double-buffered 1-bit DRAW_WIDTH x DRAW_HEIGHT framebuffer and
// upscales it by SCALE onto VGA timing (640x480 with default parameters).
// Ports:
//   clk, rst_n        : pixel clock, asynchronous active-low reset
//   fb (master)       : framebuffer read port plus swap req/ack and front_buf
//   vga_hsync/vsync   : active-low syncs
//   vga_de            : active-video enable
//   vga_rgb           : {r,g,b} 4 bits each, 0 outside active video
// All VGA outputs share one pipeline of READ_LATENCY+2 stages measured
// from the sx/sy counter state.
module framebuffer_scanout #(
   parameter int unsigned DRAW_WIDTH   = 320,
   parameter int unsigned DRAW_HEIGHT  = 240,
   parameter int unsigned DRAW_ADDRW   = $clog2(DRAW_WIDTH * DRAW_HEIGHT),
   parameter int unsigned SCALE        = 2,
   parameter int unsigned H_FP         = 16,
   parameter int unsigned H_SYNC       = 96,
   parameter int unsigned H_BP         = 48,
   parameter int unsigned V_FP         = 10,
   parameter int unsigned V_SYNC       = 2,
   parameter int unsigned V_BP         = 33,
   parameter int unsigned READ_LATENCY = 1,
   parameter logic [11:0] FG_RGB       = 12'hFFF,
   parameter logic [11:0] BG_RGB       = 12'h000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   framebuffer_scanout_if.master fb,
   output logic                  vga_hsync,
   output logic                  vga_vsync,
   output logic                  vga_de,
   output logic [11:0]           vga_rgb
);

   localparam int unsigned H_RES   = DRAW_WIDTH * SCALE;
   localparam int unsigned V_RES   = DRAW_HEIGHT * SCALE;
   localparam int unsigned H_TOTAL = H_RES + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_RES + V_FP + V_SYNC + V_BP;
   localparam int unsigned LAT     = READ_LATENCY + 2;
   localparam int unsigned SXW     = $clog2(H_TOTAL);
   localparam int unsigned SYW     = $clog2(V_TOTAL);
   localparam int unsigned COLW    = (DRAW_WIDTH > 1) ? $clog2(DRAW_WIDTH) : 1;
   localparam int unsigned SUBW    = (SCALE > 1) ? $clog2(SCALE) : 1;

   localparam logic [SXW-1:0] SX_LAST = SXW'(H_TOTAL - 1);
   localparam logic [SXW-1:0] SX_ACT  = SXW'(H_RES);
   localparam logic [SXW-1:0] SX_HS0  = SXW'(H_RES + H_FP);
   localparam logic [SXW-1:0] SX_HS1  = SXW'(H_RES + H_FP + H_SYNC);
   localparam logic [SYW-1:0] SY_LAST = SYW'(V_TOTAL - 1);
   localparam logic [SYW-1:0] SY_ACT  = SYW'(V_RES);
   localparam logic [SYW-1:0] SY_VS0  = SYW'(V_RES + V_FP);
   localparam logic [SYW-1:0] SY_VS1  = SYW'(V_RES + V_FP + V_SYNC);
   localparam logic [SUBW-1:0] SUB_LAST = SUBW'(SCALE - 1);
   localparam logic [DRAW_ADDRW-1:0] ROW_STEP = DRAW_ADDRW'(DRAW_WIDTH);

   // run_q holds the counters at (0,0) for the first clock after reset so
   // that (0,0) is first presented in the cycle after the first active edge.
   logic                  run_q;
   logic [SXW-1:0]        sx_q, sx_d;
   logic [SYW-1:0]        sy_q, sy_d;
   logic [SUBW-1:0]       hsub_q, hsub_d;
   logic [SUBW-1:0]       vsub_q, vsub_d;
   logic [COLW-1:0]       col_q, col_d;
   logic [DRAW_ADDRW-1:0] row_q, row_d;
   logic                  front_q, front_d;
   logic                  ack_q, ack_d;
   logic [DRAW_ADDRW:0]   addr_q, addr_d;
   logic [LAT-1:0]        de_pipe_q, hs_pipe_q, vs_pipe_q;
   logic [11:0]           rgb_q;

   logic act, hs_n, vs_n, swap_pt;
   logic [DRAW_ADDRW-1:0] pix_addr;

   // Column and row base only advance while the next position is still
   // inside the active area, so neither ever leaves the framebuffer range.
   always_comb begin
      sx_d   = sx_q;
      sy_d   = sy_q;
      hsub_d = hsub_q;
      vsub_d = vsub_q;
      col_d  = col_q;
      row_d  = row_q;
      if (run_q) begin
         if (sx_q == SX_LAST) begin
            sx_d   = '0;
            hsub_d = '0;
            col_d  = '0;
            if (sy_q == SY_LAST) begin
               sy_d   = '0;
               vsub_d = '0;
               row_d  = '0;
            end else begin
               sy_d = sy_q + 1'b1;
               if (vsub_q == SUB_LAST) begin
                  vsub_d = '0;
                  if (sy_d < SY_ACT) row_d = row_q + ROW_STEP;
               end else begin
                  vsub_d = vsub_q + 1'b1;
               end
            end
         end else begin
            sx_d = sx_q + 1'b1;
            if (hsub_q == SUB_LAST) begin
               hsub_d = '0;
               if (sx_d < SX_ACT) col_d = col_q + 1'b1;
            end else begin
               hsub_d = hsub_q + 1'b1;
            end
         end
      end
   end

   always_comb begin
      act      = run_q && (sx_q < SX_ACT) && (sy_q < SY_ACT);
      hs_n     = !((sx_q >= SX_HS0) && (sx_q < SX_HS1));
      vs_n     = !((sy_q >= SY_VS0) && (sy_q < SY_VS1));
      pix_addr = row_q + DRAW_ADDRW'(col_q);
      addr_d   = {front_q, (act ? pix_addr : '0)};
      // Swap only on the edge that moves the counters onto (0, V_RES).
      swap_pt  = run_q && (sx_d == '0) && (sy_d == SY_ACT) && (sx_q == SX_LAST);
      ack_d    = swap_pt && fb.swap_req;
      front_d  = front_q ^ ack_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_q     <= 1'b0;
         sx_q      <= '0;
         sy_q      <= '0;
         hsub_q    <= '0;
         vsub_q    <= '0;
         col_q     <= '0;
         row_q     <= '0;
         front_q   <= 1'b0;
         ack_q     <= 1'b0;
         addr_q    <= '0;
         de_pipe_q <= '0;
         hs_pipe_q <= '1;
         vs_pipe_q <= '1;
         rgb_q     <= '0;
      end else begin
         run_q     <= 1'b1;
         sx_q      <= sx_d;
         sy_q      <= sy_d;
         hsub_q    <= hsub_d;
         vsub_q    <= vsub_d;
         col_q     <= col_d;
         row_q     <= row_d;
         front_q   <= front_d;
         ack_q     <= ack_d;
         addr_q    <= addr_d;
         de_pipe_q <= {de_pipe_q[LAT-2:0], act};
         hs_pipe_q <= {hs_pipe_q[LAT-2:0], hs_n};
         vs_pipe_q <= {vs_pipe_q[LAT-2:0], vs_n};
         // Read data is valid alongside stage LAT-2; registering it here
         // lines it up with the last delay-line stage.
         rgb_q     <= de_pipe_q[LAT-2] ? (fb.draw_data_out ? FG_RGB : BG_RGB) : '0;
      end
   end

   assign fb.draw_addr_read = addr_q;
   assign fb.swap_ack       = ack_q;
   assign fb.front_buf      = front_q;
   assign vga_de            = de_pipe_q[LAT-1];
   assign vga_hsync         = hs_pipe_q[LAT-1];
   assign vga_vsync         = vs_pipe_q[LAT-1];
   assign vga_rgb           = rgb_q;

endmodule

// File: tb/tb_framebuffer_scanout.sv
// Directed bench for framebuffer_scanout on a reduced 20x6 framebuffer
// (40x12 active, 55 clocks/line, 19 lines/frame, 1045 clocks/frame).
// Cycle t=0 is the first cycle after the first rising edge with rst_n high;
// the counters sit at position t in that cycle, the address shows t-1 and
// the VGA outputs show t-3.
module tb_framebuffer_scanout;
   localparam int DW = 20, HRES = 40, VRES = 12;
   localparam int HFP = 4, HSYNC = 6, VFP = 2, VSYNC = 2;
   localparam int HT = 55, VT = 19, FRAME = 1045;
   localparam int AW = 7, NBIN = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        vga_hsync, vga_vsync, vga_de;
   logic [11:0] vga_rgb;

   framebuffer_scanout_if #(.ADDRW(AW)) fb_if ();

   framebuffer_scanout #(
      .DRAW_WIDTH(20), .DRAW_HEIGHT(6), .SCALE(2),
      .H_FP(4), .H_SYNC(6), .H_BP(5),
      .V_FP(2), .V_SYNC(2), .V_BP(3)
   ) dut (
      .clk(clk), .rst_n(rst_n), .fb(fb_if),
      .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
      .vga_de(vga_de), .vga_rgb(vga_rgb)
   );

   always #5 clk = ~clk;

   int n_checks = 0, n_pass = 0;
   int mode = 0;
   bit auto_drop = 1'b0;

   int t;
   logic front_m;
   logic fhist [4];
   int de_cnt_f [NBIN], fg_cnt_f [NBIN], msb_cnt_f [NBIN], ack_cnt_f [NBIN];
   int err_de, err_hs, err_vs, err_rgb, err_addr, err_ack, err_front;
   int hs_fall_t, hs_rise_t, vs_fall_t, vs_rise_t, de_rises, de_rise2_t, de_rise13_t;
   int ack_t, addr_last, max_addr;
   logic prev_de, prev_hs, prev_vs;

   // mode 0: pixel(x,y)=(x^y)&1 in both buffers; mode 1: buffer 0 zeros, buffer 1 ones
   function automatic logic mem_pix(input logic [AW:0] a);
      int lin, x, y;
      lin = int'(a[AW-1:0]);
      x = lin % DW;
      y = lin / DW;
      if (mode == 0) return 1'((x ^ y) & 1);
      return a[AW];
   endfunction

   function automatic logic model_pix(input logic bsel, input int fx, input int fy);
      if (mode == 0) return 1'((fx ^ fy) & 1);
      return bsel;
   endfunction

   always @(posedge clk) fb_if.draw_data_out <= mem_pix(fb_if.draw_addr_read);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: observed %0d expected %0d", tag, got, exp);
   endtask

   task automatic reset_model();
      t = 0;
      front_m = 1'b0;
      for (int i = 0; i < 4; i++) fhist[i] = 1'b0;
      for (int i = 0; i < NBIN; i++) begin
         de_cnt_f[i] = 0; fg_cnt_f[i] = 0; msb_cnt_f[i] = 0; ack_cnt_f[i] = 0;
      end
      err_de = 0; err_hs = 0; err_vs = 0; err_rgb = 0;
      err_addr = 0; err_ack = 0; err_front = 0;
      hs_fall_t = -1; hs_rise_t = -1; vs_fall_t = -1; vs_rise_t = -1;
      de_rises = 0; de_rise2_t = -1; de_rise13_t = -1;
      ack_t = -1; addr_last = -1; max_addr = 0;
      prev_de = 1'b0; prev_hs = 1'b1; prev_vs = 1'b1;
   endtask

   // One clock: compare every DUT output with the timing model for cycle t.
   task automatic step();
      int csx, csy, q, asx, asy, p, osx, osy, a_obs;
      logic exp_ack, exp_de, exp_hs, exp_vs;
      logic [11:0] exp_rgb;
      logic [AW:0] exp_addr;
      @(negedge clk);
      csx = t % HT;
      csy = (t / HT) % VT;
      exp_ack = 1'b0;
      if (t > 0 && csx == 0 && csy == VRES && fb_if.swap_req === 1'b1) begin
         front_m = ~front_m;
         exp_ack = 1'b1;
      end
      fhist[t % 4] = front_m;
      if (fb_if.swap_ack !== exp_ack) err_ack++;
      if (fb_if.front_buf !== front_m) err_front++;
      if (fb_if.swap_ack === 1'b1) begin
         ack_t = t;
         if (t / FRAME < NBIN) ack_cnt_f[t / FRAME]++;
      end

      exp_addr = '0;
      if (t >= 1) begin
         q = t - 1;
         asx = q % HT;
         asy = (q / HT) % VT;
         exp_addr[AW] = fhist[q % 4];
         if (asx < HRES && asy < VRES) begin
            exp_addr[AW-1:0] = AW'((asx / 2) + (asy / 2) * DW);
            if (fb_if.draw_addr_read[AW] === 1'b1 && q / FRAME < NBIN) msb_cnt_f[q / FRAME]++;
         end
      end
      if (fb_if.draw_addr_read !== exp_addr) err_addr++;
      a_obs = int'(fb_if.draw_addr_read[AW-1:0]);
      if (a_obs > max_addr) max_addr = a_obs;
      if (t == 645) addr_last = a_obs;

      exp_de = 1'b0; exp_hs = 1'b1; exp_vs = 1'b1; exp_rgb = 12'h000;
      if (t >= 3) begin
         p = t - 3;
         osx = p % HT;
         osy = (p / HT) % VT;
         exp_de = (osx < HRES) && (osy < VRES);
         exp_hs = !(osx >= HRES + HFP && osx < HRES + HFP + HSYNC);
         exp_vs = !(osy >= VRES + VFP && osy < VRES + VFP + VSYNC);
         if (exp_de) exp_rgb = model_pix(fhist[p % 4], osx / 2, osy / 2) ? 12'hFFF : 12'h000;
         if (p / FRAME < NBIN) begin
            if (vga_de === 1'b1) de_cnt_f[p / FRAME]++;
            if (vga_de === 1'b1 && vga_rgb === 12'hFFF) fg_cnt_f[p / FRAME]++;
         end
      end
      if (vga_de !== exp_de) err_de++;
      if (vga_hsync !== exp_hs) err_hs++;
      if (vga_vsync !== exp_vs) err_vs++;
      if (vga_rgb !== exp_rgb) err_rgb++;

      if (prev_hs === 1'b1 && vga_hsync === 1'b0 && hs_fall_t < 0) hs_fall_t = t;
      if (prev_hs === 1'b0 && vga_hsync === 1'b1 && hs_rise_t < 0) hs_rise_t = t;
      if (prev_vs === 1'b1 && vga_vsync === 1'b0 && vs_fall_t < 0) vs_fall_t = t;
      if (prev_vs === 1'b0 && vga_vsync === 1'b1 && vs_rise_t < 0) vs_rise_t = t;
      if (prev_de === 1'b0 && vga_de === 1'b1) begin
         de_rises++;
         if (de_rises == 2) de_rise2_t = t;
         if (de_rises == 13) de_rise13_t = t;
      end
      prev_de = vga_de; prev_hs = vga_hsync; prev_vs = vga_vsync;

      if (auto_drop && fb_if.swap_ack === 1'b1) fb_if.swap_req = 1'b0;
      t++;
   endtask

   task automatic run_to(input int target);
      if (target - t > 20000 || target < t) check("run_to_budget", 32'(target), 32'(t));
      else while (t < target) step();
   endtask

   task automatic check_errs(input string ep);
      check({ep, "_err_de"}, 32'(err_de), 0);
      check({ep, "_err_hsync"}, 32'(err_hs), 0);
      check({ep, "_err_vsync"}, 32'(err_vs), 0);
      check({ep, "_err_rgb"}, 32'(err_rgb), 0);
      check({ep, "_err_addr"}, 32'(err_addr), 0);
      check({ep, "_err_ack"}, 32'(err_ack), 0);
      check({ep, "_err_front"}, 32'(err_front), 0);
   endtask

   // Release reset between edges, then check the first four cycles.
   task automatic release_and_check();
      reset_model();
      rst_n = 1'b1;
      @(posedge clk);
      for (int i = 0; i < 4; i++) begin
         step();
         check("rel_de", 32'(vga_de), (i == 3) ? 1 : 0);
         check("rel_hsync", 32'(vga_hsync), 1);
         check("rel_vsync", 32'(vga_vsync), 1);
         check("rel_rgb", 32'(vga_rgb), 0);
         check("rel_addr", 32'(fb_if.draw_addr_read), (i == 3) ? 1 : 0);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_de"}, 32'(vga_de), 0);
      check({tag, "_hsync"}, 32'(vga_hsync), 1);
      check({tag, "_vsync"}, 32'(vga_vsync), 1);
      check({tag, "_rgb"}, 32'(vga_rgb), 0);
      check({tag, "_front"}, 32'(fb_if.front_buf), 0);
      check({tag, "_ack"}, 32'(fb_if.swap_ack), 0);
      check({tag, "_addr"}, 32'(fb_if.draw_addr_read), 0);
   endtask

   initial begin
      rst_n = 1'b0;
      fb_if.swap_req = 1'b0;
      mode = 0;
      repeat (3) @(negedge clk);
      check_reset_outputs("in_reset");

      // Epoch 1: reset release, two checkerboard frames, swap handshakes.
      release_and_check();
      run_to(1981);
      mode = 1;
      run_to(2311);
      fb_if.swap_req = 1'b1;
      auto_drop = 1'b1;
      run_to(4181);
      auto_drop = 1'b0;
      run_to(4401);
      fb_if.swap_req = 1'b1;
      run_to(4621);
      fb_if.swap_req = 1'b0;
      run_to(5676);

      check("hs_fall_t", 32'(hs_fall_t), 47);
      check("hs_rise_t", 32'(hs_rise_t), 53);
      check("vs_fall_t", 32'(vs_fall_t), 773);
      check("vs_rise_t", 32'(vs_rise_t), 883);
      check("de_line2_t", 32'(de_rise2_t), 58);
      check("de_frame2_t", 32'(de_rise13_t), 1048);
      for (int i = 0; i < 5; i++) check("de_per_frame", 32'(de_cnt_f[i]), 480);
      check("addr_last_px", 32'(addr_last), 119);
      check("addr_max", 32'(max_addr), 119);
      check("f2_fg_px", 32'(fg_cnt_f[2]), 0);
      check("f2_msb_addr", 32'(msb_cnt_f[2]), 0);
      check("f2_ack_cnt", 32'(ack_cnt_f[2]), 1);
      check("ack_time", 32'(ack_t), 2750);
      check("f3_fg_px", 32'(fg_cnt_f[3]), 480);
      check("f3_msb_addr", 32'(msb_cnt_f[3]), 480);
      check("f3_ack_cnt", 32'(ack_cnt_f[3]), 0);
      check("f4_ack_cnt", 32'(ack_cnt_f[4]), 0);
      check("f4_fg_px", 32'(fg_cnt_f[4]), 480);
      check_errs("ep1");

      // Mid-frame asynchronous reset while displaying buffer 1.
      check("pre_rst_de", 32'(vga_de), 1);
      check("pre_rst_front", 32'(fb_if.front_buf), 1);
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("async_rst");
      mode = 0;
      @(negedge clk);
      @(negedge clk);

      // Epoch 2: timing restarts from the origin.
      release_and_check();
      run_to(1049);
      check("ep2_hs_fall_t", 32'(hs_fall_t), 47);
      check("ep2_de_frame", 32'(de_cnt_f[0]), 480);
      check("ep2_addr_max", 32'(max_addr), 119);
      check("ep2_front", 32'(fb_if.front_buf), 0);
      check_errs("ep2");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
